rom_fetch_sequencer: RTL
========================

// Module: rom_fetch_sequencer
// PURPOSE
//  Initiator side of the 4Kx8 program ROM (rom_mem): owns the 12-bit program counter, drives the ROM address,
//  captures the returned byte into an instruction register and hands it downstream over a valid/ready handshake.
//  Sits between rom_mem and the Lab decode/execute logic; supports load, single-step and continuous run.
// PARAMETERS
//  ADDR_W    12  ROM address width (PC width); PC wraps modulo 2**ADDR_W
//  DATA_W    8   ROM data width; opcode = upper half, operand = lower half
//  WAIT_CYC  0   extra cycles held in ADDR before capture (0..7), for slower ROM implementations
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  load        in   1       load PC from load_addr (priority over everything but reset)
//  load_addr   in   ADDR_W  new PC value
//  run         in   1       level: fetch continuously while high
//  step        in   1       pulse: fetch exactly one instruction (sampled in IDLE only)
//  mem_addr    out  ADDR_W  address to rom_mem (registered, = pc)
//  mem_data    in   DATA_W  data from rom_mem (combinational read)
//  instr_valid out  1       instr/instr_addr hold a fetched byte
//  instr_ready in   1       consumer accepts instr this cycle
//  instr       out  DATA_W  instruction register
//  opcode      out  DATA_W/2  instr[DATA_W-1:DATA_W/2]
//  operand     out  DATA_W/2  instr[DATA_W/2-1:0]
//  instr_addr  out  ADDR_W  address the current instr was fetched from
//  pc          out  ADDR_W  next address to fetch
//  busy        out  1       state != IDLE
//  wrapped     out  1       one-cycle pulse when pc steps 2**ADDR_W-1 -> 0
// BEHAVIOUR
//  Reset: state IDLE; pc, mem_addr, instr, instr_addr = 0; instr_valid, busy, wrapped = 0; wait counter = 0.
//  FSM states IDLE, ADDR, HOLD (registered):
//   IDLE: load -> pc<=load_addr, stay IDLE. Else run|step -> ADDR (latch single=step&~run). Else stay.
//   ADDR: mem_addr=pc stable; count wait counter 0..WAIT_CYC; on edge where count==WAIT_CYC:
//         instr<=mem_data, instr_addr<=pc, pc<=pc+1, instr_valid<=1, -> HOLD.
//   HOLD: instr_valid=1, instr/instr_addr stable until instr_ready=1. On handshake:
//         instr_valid<=0; if run & ~single -> ADDR else -> IDLE. No handshake -> stay (backpressure, no fetch).
//  load in ADDR or HOLD: aborts, pc<=load_addr, instr_valid<=0, -> IDLE; in-flight byte discarded.
//  Latency: run/step sampled in IDLE at edge N -> instr_valid high after edge N+1+WAIT_CYC.
//  Continuous run, instr_ready tied 1: one instruction per (2+WAIT_CYC) cycles, addresses strictly ascending.
//  Dropping run while in ADDR: fetch completes, HOLD, then IDLE after handshake.
//  step while run high: ignored (run governs). step outside IDLE: ignored.
//  PC arithmetic unsigned ADDR_W bits; 0xFFF+1 = 0x000 with wrapped=1 for that single cycle (capture edge+1).
//  mem_addr always equals pc (single register, no glitch between states).
// STRUCTURE
//  Package fetch_pkg: state localparams (S_IDLE=2'd0, S_ADDR=2'd1, S_HOLD=2'd2), ADDR_W/DATA_W defaults.
//  One natural sub-module: fetch_pc (PC register with load/increment/wrap flag); FSM + IR stay in top.
// TESTING (bench instantiates rom_mem with its memory image; reference model reads same image)
//  Reset held 2 cycles -> pc=0x000, instr_valid=0, busy=0, wrapped=0, instr=0x00.
//  load 0x010, step pulse, ready=1 -> instr_valid 2 cycles after step, instr=rom[0x010], instr_addr=0x010, pc=0x011, then IDLE.
//  load 0x100, run=1, ready=1 for 12 cycles -> bytes rom[0x100..0x105] in order, one every 2 cycles.
//  run at 0x011, ready=0 for 5 cycles -> instr=rom[0x011] stable, pc=0x012, no new mem_addr change; ready=1 resumes.
//  load 0xFFF, run -> instr_addr=0xFFF, pc=0x000, wrapped pulses once; next fetch instr_addr=0x000.
//  load 0x014 asserted during ADDR -> instr_valid never rises, pc=0x014, IDLE; WAIT_CYC=2 build: latency 4 cycles.

Source files
------------

// File: rtl/rom_fetch_sequencer_pkg.sv
// fetch_pkg: shared state encodings and default widths for the ROM fetch sequencer
//   S_IDLE/S_ADDR/S_HOLD : fetch FSM state codes
//   ADDR_W_DEF/DATA_W_DEF: default ROM address/data widths
package fetch_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
endpackage

// File: rtl/rom_fetch_sequencer_pc.sv
// fetch_pc: program counter with load, increment and wrap pulse
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : load pc from load_addr_i (beats increment)
//   inc_i          : advance pc by one (modulo 2**ADDR_W)
//   pc_o           : current program counter
//   wrapped_o      : one-cycle pulse after pc stepped from all-ones to zero
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              wrapped_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              wrapped_q, wrapped_d;
    always_comb begin
        pc_d      = load_i ? load_addr_i : inc_i ? pc_q + 1'b1 : pc_q;
        wrapped_d = ~load_i & inc_i & (&pc_q);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q      <= '0;
            wrapped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
        end
    end
    assign pc_o      = pc_q;
    assign wrapped_o = wrapped_q;
endmodule

// File: rtl/rom_fetch_sequencer.sv
// rom_fetch_sequencer: fetches program ROM bytes into an instruction register with valid/ready hand-off
//   clk_i, reset_i   : clock, synchronous active-high reset
//   load_i/load_addr_i : load pc (aborts any fetch in flight)
//   run_i / step_i   : continuous fetch level / single fetch pulse (sampled in IDLE)
//   mem_addr_o/mem_data_i : ROM address (= pc) and combinational read data
//   instr_valid_o/instr_ready_i : downstream handshake
//   instr_o, opcode_o, operand_o, instr_addr_o : captured byte, its halves, its address
//   pc_o, busy_o, wrapped_o : next fetch address, FSM not idle, pc wrap pulse
module rom_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic [ADDR_W-1:0]   load_addr_i,
    input  logic                run_i,
    input  logic                step_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [DATA_W-1:0]   instr_o,
    output logic [DATA_W/2-1:0] opcode_o,
    output logic [DATA_W/2-1:0] operand_o,
    output logic [ADDR_W-1:0]   instr_addr_o,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                busy_o,
    output logic                wrapped_o
);
    localparam int H = DATA_W / 2;
    logic [1:0]        state_q, state_d;
    logic              single_q, single_d;
    logic [2:0]        wait_q, wait_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] iaddr_q, iaddr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc;
    logic              capture;
    // load wins over a capture landing on the same edge, so the byte is dropped
    assign capture = ~load_i & (state_q == S_ADDR) & (wait_q == 3'(WAIT_CYC));
    fetch_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load_i),
        .load_addr_i (load_addr_i),
        .inc_i       (capture),
        .pc_o        (pc),
        .wrapped_o   (wrapped_o)
    );
    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        wait_d   = wait_q;
        instr_d  = instr_q;
        iaddr_d  = iaddr_q;
        valid_d  = valid_q;
        if (load_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            wait_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i | step_i) begin
                        state_d  = S_ADDR;
                        single_d = step_i & ~run_i;
                        wait_d   = '0;
                    end
                end
                S_ADDR: begin
                    if (capture) begin
                        instr_d = mem_data_i;
                        iaddr_d = pc;
                        valid_d = 1'b1;
                        wait_d  = '0;
                        state_d = S_HOLD;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready_i) begin
                        valid_d = 1'b0;
                        state_d = (run_i & ~single_q) ? S_ADDR : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            single_q <= 1'b0;
            wait_q   <= '0;
            instr_q  <= '0;
            iaddr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            wait_q   <= wait_d;
            instr_q  <= instr_d;
            iaddr_q  <= iaddr_d;
            valid_q  <= valid_d;
        end
    end
    assign mem_addr_o    = pc;
    assign pc_o          = pc;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[DATA_W-1:H];
    assign operand_o     = instr_q[H-1:0];
    assign instr_addr_o  = iaddr_q;
    assign busy_o        = (state_q != S_IDLE);
endmodule
